// File: rtl/fir_tdm_mac_sequencer_if.sv
// Stream, coefficient-port and status bundle for the time-multiplexed FIR MAC sequencer.
// The master side drives samples and coefficient writes; the slave side is the sequencer.
interface fir_tdm_mac_sequencer_if #(
  parameter int N       = 24,
  parameter int N_COEFF = 16,
  parameter int N_TAPS  = 9
);
  localparam int AW = $clog2(N_TAPS);

  logic               in_valid;
  logic [N-1:0]       in_data;
  logic               in_ready;
  logic               out_valid;
  logic [N-1:0]       out_data;
  logic               out_ready;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic [N_COEFF-1:0] coef_wdata;
  logic               coef_err;
  logic               busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err, busy
  );
endinterface

// File: rtl/fir_tdm_mac_sequencer.sv
// Time-multiplexed 9-tap FIR: one shared signed MAC walks the circular sample buffer
// over N_TAPS cycles per sample, bit-exact with the direct-form sum and output slice.
module fir_tdm_mac_sequencer #(
  parameter int N       = 24,
  parameter int N_COEFF = 16,
  parameter int N_TAPS  = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  fir_tdm_mac_sequencer_if.slave    bus
);
  localparam int AW = $clog2(N_TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic signed [N-1:0]       r_buf  [N_TAPS];
  logic signed [N_COEFF-1:0] r_coef [N_TAPS];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_k;
  logic signed [2*N-1:0]     r_acc;
  logic [N-1:0]              r_out_data;
  logic                      r_out_valid;
  logic                      r_coef_err;
  logic                      r_in_ready;
  logic                      r_busy;

  logic                      w_accept;
  logic                      w_last;
  logic [AW-1:0]             w_next_ptr;
  logic [AW:0]               w_rd_sum;
  logic [AW-1:0]             w_rd_idx;
  logic signed [2*N-1:0]     w_coef_ext;
  logic signed [2*N-1:0]     w_samp_ext;
  logic signed [2*N-1:0]     w_prod;
  logic signed [2*N-1:0]     w_acc_next;
  logic                      w_addr_ok;
  logic                      w_coef_wr_ok;

  // Power-on coefficient bank: symmetric low-pass taps, zero beyond the ninth tap.
  function automatic logic [N_COEFF-1:0] default_coef(input int idx);
    logic [15:0] v;
    case (idx)
      32'sd0, 32'sd8: v = 16'h17CC;
      32'sd1, 32'sd7: v = 16'h0510;
      32'sd2, 32'sd6: v = 16'h055F;
      32'sd3, 32'sd5: v = 16'h0594;
      32'sd4:         v = 16'h05A9;
      default:        v = 16'h0000;
    endcase
    return N_COEFF'(v);
  endfunction

  // Handshake qualifiers, circular pointer arithmetic and the shared MAC datapath.
  always_comb begin
    w_accept     = bus.in_valid && (r_state == S_IDLE);
    w_last       = (r_k == AW'(N_TAPS - 1));
    w_next_ptr   = (r_wr_ptr == AW'(N_TAPS - 1)) ? {AW{1'b0}} : (r_wr_ptr + AW'(1));
    if (r_wr_ptr >= r_k) begin
      w_rd_sum = {1'b0, r_wr_ptr} - {1'b0, r_k};
    end else begin
      w_rd_sum = {1'b0, r_wr_ptr} + (AW+1)'(N_TAPS) - {1'b0, r_k};
    end
    w_rd_idx     = w_rd_sum[AW-1:0];
    w_coef_ext   = (2*N)'(r_coef[r_k]);
    w_samp_ext   = (2*N)'(r_buf[w_rd_idx]);
    w_prod       = w_coef_ext * w_samp_ext;
    w_acc_next   = r_acc + w_prod;
    w_addr_ok    = ({1'b0, bus.coef_addr} < (AW+1)'(N_TAPS));
    w_coef_wr_ok = bus.coef_we && w_addr_ok && (r_state == S_IDLE);
  end

  // Next-state decode for the IDLE -> MAC -> OUT sample cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_MAC;
        else          w_next_state = S_IDLE;
      end
      S_MAC: begin
        if (w_last) w_next_state = S_OUT;
        else        w_next_state = S_MAC;
      end
      S_OUT: begin
        if (bus.out_ready) w_next_state = S_IDLE;
        else               w_next_state = S_OUT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register plus ready/busy flags registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
      r_busy     <= (w_next_state != S_IDLE);
    end
  end

  // Accumulator, tap counter, write pointer and the held output result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_k         <= {AW{1'b0}};
      r_acc       <= {(2*N){1'b0}};
      r_out_data  <= {N{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr_ptr <= w_next_ptr;
            r_acc    <= {(2*N){1'b0}};
            r_k      <= {AW{1'b0}};
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            // Bit 2N-1 is the wrap bit; the N-bit result is the floor of acc / 2^(N-1).
            r_out_data  <= w_acc_next[2*N-2:N-1];
            r_out_valid <= 1'b1;
            r_k         <= {AW{1'b0}};
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_k         <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Sample buffer and coefficient bank; a same-cycle write lands before the first MAC read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 32'sd0; i < N_TAPS; i++) begin
        r_buf[i]  <= {N{1'b0}};
        r_coef[i] <= default_coef(i);
      end
    end else begin
      if (w_accept)     r_buf[w_next_ptr]      <= $signed(bus.in_data);
      if (w_coef_wr_ok) r_coef[bus.coef_addr] <= $signed(bus.coef_wdata);
    end
  end

  // Rejected coefficient writes (busy or out-of-range index) flag an error the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_coef_err <= 1'b0;
    else          r_coef_err <= bus.coef_we && !w_coef_wr_ok;
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.coef_err  = r_coef_err;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_fir_tdm_mac_sequencer.sv
// Randomized self-checking bench for fir_tdm_mac_sequencer against a direct-form FIR model
// held as a newest-first sample history and a plain coefficient array.
module tb_fir_tdm_mac_sequencer;
  localparam int N  = 24;
  localparam int NC = 16;
  localparam int NT = 9;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  fir_tdm_mac_sequencer_if #(.N(N), .N_COEFF(NC), .N_TAPS(NT)) bus ();

  fir_tdm_mac_sequencer #(.N(N), .N_COEFF(NC), .N_TAPS(NT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: newest sample first; absent history counts as zero.
  int m_coef [NT];
  int m_hist [$];
  int imp [10] = '{32'h0BE6, 32'h0288, 32'h02AF, 32'h02CA, 32'h02D4,
                   32'h02CA, 32'h02AF, 32'h0288, 32'h0BE6, 32'h0000};

  function automatic void m_reset();
    m_hist.delete();
    m_coef = '{32'sh17CC, 32'sh0510, 32'sh055F, 32'sh0594, 32'sh05A9,
               32'sh0594, 32'sh055F, 32'sh0510, 32'sh17CC};
  endfunction

  function automatic void m_push(input logic [N-1:0] x);
    m_hist.push_front(int'($signed(x)));
    if (m_hist.size() > NT) void'(m_hist.pop_back());
  endfunction

  function automatic logic [N-1:0] m_out();
    longint      s = 0;
    logic [63:0] u;
    for (int k = 0; k < NT; k++)
      if (k < m_hist.size()) s += longint'(m_coef[k]) * longint'(m_hist[k]);
    u = s;
    return u[2*N-2:N-1];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_return", bus.in_ready, 1'b1);
  endtask

  // One sample with out_ready high, optionally with a coefficient write in the same cycle.
  task automatic do_sample(input logic [N-1:0] x, input logic we, input logic [3:0] addr,
                           input logic [15:0] wd, output logic [N-1:0] y);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_data    = x;
    bus.coef_we    = we;
    bus.coef_addr  = addr;
    bus.coef_wdata = wd;
    tick();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    chk("coef_err_same_cycle", bus.coef_err, (we && addr >= NT));
    if (we && addr < NT) m_coef[addr] = int'($signed(wd));
    m_push(x);
    wait_out_valid(n);
    chk("latency", n, 9);
    y = bus.out_data;
    chk("out_data", y, m_out());
    wait_in_ready();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_reset();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [N-1:0] y;
    logic [N-1:0] x;
    logic [N-1:0] held;
    int           n;

    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    m_reset();
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 24'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_coef_err", bus.coef_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // Positive impulse with default coefficients, plus one trailing zero.
    for (int i = 0; i < 10; i++) begin
      do_sample((i == 0) ? 24'h400000 : 24'h000000, 1'b0, 4'd0, 16'h0, y);
      chk("impulse", y, imp[i]);
    end

    // Negative impulse: floor truncation of the odd halves.
    for (int i = 0; i < NT; i++) begin
      do_sample((i == 0) ? 24'hC00000 : 24'h000000, 1'b0, 4'd0, 16'h0, y);
      if (i == 0) chk("neg_first", y, 24'hFFF41A);
      if (i == 4) chk("neg_fifth", y, 24'hFFFD2B);
    end

    // Backpressure: result held, input stalled, stray in_valid pulses ignored.
    bus.out_ready = 1'b0;
    x = 24'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    tick();
    bus.in_valid = 1'b0;
    m_push(x);
    wait_out_valid(n);
    chk("bp_latency", n, 9);
    held = bus.out_data;
    chk("bp_data", held, m_out());
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 24'($urandom);
      tick();
      chk("bp_hold", bus.out_data, held);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 1'b0);
    chk("bp_release_ready", bus.in_ready, 1'b1);
    chk("bp_release_busy", bus.busy, 1'b0);
    do_sample(24'($urandom), 1'b0, 4'd0, 16'h0, y);

    // Cycle-exact timing: in_valid driven after edge 0, sampled at edge 1.
    x = 24'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    m_push(x);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) bus.in_valid = 1'b0;
      if (c == 1) chk("t_busy_after_accept", bus.busy, 1'b1);
      if (c == 9) chk("t_valid_early", bus.out_valid, 1'b0);
      if (c == 10) begin
        chk("t_valid_rise", bus.out_valid, 1'b1);
        chk("t_in_ready_out", bus.in_ready, 1'b0);
        chk("t_data", bus.out_data, m_out());
      end
      if (c == 11) begin
        chk("t_valid_fall", bus.out_valid, 1'b0);
        chk("t_in_ready_rise", bus.in_ready, 1'b1);
      end
    end

    // Coefficient rewrite in IDLE.
    do_reset();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 16'h7FFF;
    tick();
    bus.coef_we = 1'b0;
    m_coef[0] = 32'sh7FFF;
    chk("cw_no_err", bus.coef_err, 1'b0);
    do_sample(24'h400000, 1'b0, 4'd0, 16'h0, y);
    chk("cw_first", y, 24'h003FFF);

    // Coefficient write during MAC is dropped and flagged.
    x = 24'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    tick();
    bus.in_valid = 1'b0;
    m_push(x);
    tick();
    tick();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd1;
    bus.coef_wdata = 16'h1234;
    tick();
    bus.coef_we = 1'b0;
    chk("mac_we_err", bus.coef_err, 1'b1);
    tick();
    chk("mac_we_err_pulse", bus.coef_err, 1'b0);
    wait_out_valid(n);
    chk("mac_we_data", bus.out_data, m_out());
    wait_in_ready();
    do_sample(24'($urandom), 1'b0, 4'd0, 16'h0, y);

    // Out-of-range index is rejected.
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd9;
    bus.coef_wdata = 16'h4000;
    tick();
    bus.coef_we = 1'b0;
    chk("addr9_err", bus.coef_err, 1'b1);
    tick();
    chk("addr9_err_pulse", bus.coef_err, 1'b0);

    // Random samples with occasional same-cycle coefficient writes (some out of range).
    for (int i = 0; i < 25; i++) begin
      do_sample(24'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 11)),
                16'($urandom), y);
    end

    // Asynchronous reset in MAC cycle 4.
    bus.in_valid = 1'b1;
    bus.in_data  = 24'($urandom_range(1, 24'h7FFFFF));
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("amr_in_ready", bus.in_ready, 1'b1);
    chk("amr_busy", bus.busy, 1'b0);
    chk("amr_out_valid", bus.out_valid, 1'b0);
    chk("amr_out_data", bus.out_data, 24'h0);
    chk("amr_coef_err", bus.coef_err, 1'b0);
    m_reset();
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.out_valid) n++;
    end
    chk("amr_no_valid", n, 0);
    for (int i = 0; i < NT; i++) begin
      do_sample((i == 0) ? 24'h400000 : 24'h000000, 1'b0, 4'd0, 16'h0, y);
      chk("amr_impulse", y, imp[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
